// File: rtl/dds_sample_framer.sv
// dds_sample_framer
//   DDS sample source feeding the SPI main DAC link. A programmable divider
//   produces sample ticks. Each tick advances a phase accumulator and maps the
//   new phase to a 12-bit waveform sample. The sample is packed with a command
//   nibble into a 16-bit word, which is offered to the SPI main stage through a
//   load/csb handshake. A tick that arrives while a transfer is still in flight
//   drops its sample and sets the sticky overrun flag.
//
// Ports
//   sys_clk       system clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable        run sample generation
//   tuning_word   phase increment per sample
//   rate_div      sample period = rate_div+1 cycles
//   wave_sel      00 saw, 01 square, 10 triangle, 11 midscale DC
//   cmd           command nibble placed in the top of the word
//   csb           chip select from SPI main (low = transfer in progress)
//   clr_overrun   clears the overrun flag
//   parallel_out  word presented to SPI main
//   load          word-valid request to SPI main
//   sample_tick   one-cycle strobe per generated sample
//   overrun       sticky flag: a sample was dropped
module dds_sample_framer #(
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ACC_WIDTH-1:0]  tuning_word,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  input  logic [1:0]            wave_sel,
  input  logic [3:0]            cmd,
  input  logic                  csb,
  input  logic                  clr_overrun,
  output logic [WORD_WIDTH-1:0] parallel_out,
  output logic                  load,
  output logic                  sample_tick,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [ACC_WIDTH-1:0]  phase;
  logic [ACC_WIDTH-1:0]  phase_next;
  logic                  tick;
  logic [DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH-1:0] p_dbl;
  logic [DATA_WIDTH-1:0] sample;

  // Sample is derived from the phase value being written on this tick.
  always_comb begin
    tick       = enable && (cnt == '0);
    phase_next = phase + tuning_word;
    p          = phase_next[ACC_WIDTH-1 -: DATA_WIDTH];
    p_dbl      = {p[DATA_WIDTH-2:0], 1'b0};
    sample     = '0;
    case (wave_sel)
      2'b00:   sample = p;
      2'b01:   sample = p[DATA_WIDTH-1] ? '1 : '0;
      2'b10:   sample = p[DATA_WIDTH-1] ? ~p_dbl : p_dbl;
      default: sample = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    endcase
  end

  // Divider: first tick lands on the first enabled cycle, then every
  // rate_div+1 cycles; dropping enable parks the counter at zero.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      phase       <= '0;
      sample_tick <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sample_tick <= tick;
      if (!enable)
        cnt <= '0;
      else if (cnt == '0)
        cnt <= rate_div;
      else
        cnt <= cnt - DIV_WIDTH'(1);

      if (tick)
        phase <= phase_next;

      // Setting wins over a simultaneous clear.
      if (tick && (state != IDLE))
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      load         <= 1'b0;
      parallel_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            parallel_out <= {cmd, sample};
            load         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (!csb) begin
            load  <= 1'b0;
            state <= SEND;
          end
        end
        SEND: begin
          if (csb)
            state <= IDLE;
        end
        default: begin
          load  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sample_framer.sv
// Testbench for dds_sample_framer: cycle-level scoreboard of words, load,
// overrun and tick spacing, with a csb stub standing in for the SPI main.
module tb_dds_sample_framer;

  logic        sys_clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] tuning_word;
  logic [15:0] rate_div;
  logic [1:0]  wave_sel;
  logic [3:0]  cmd;
  logic        csb;
  logic        clr_overrun;
  logic [15:0] parallel_out;
  logic        load;
  logic        sample_tick;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // csb stub controls
  logic stub_on;
  int   stub_delay;
  int   stub_hold;

  // Scoreboards: model-derived words and literal words from the test plan.
  logic [15:0] sb_q[$];
  logic [15:0] lit_q[$];

  dds_sample_framer #(
    .ACC_WIDTH (24),
    .DATA_WIDTH(12),
    .WORD_WIDTH(16),
    .DIV_WIDTH (16)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .tuning_word (tuning_word),
    .rate_div    (rate_div),
    .wave_sel    (wave_sel),
    .cmd         (cmd),
    .csb         (csb),
    .clr_overrun (clr_overrun),
    .parallel_out(parallel_out),
    .load        (load),
    .sample_tick (sample_tick),
    .overrun     (overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [23:0] ph, input logic [1:0] ws,
                                           input logic [3:0] c);
    int unsigned pv;
    int unsigned s;
    pv = int'(ph) / 4096;
    case (ws)
      2'd0: s = pv;
      2'd1: s = (pv >= 2048) ? 4095 : 0;
      2'd2: begin
        s = (pv * 2) % 4096;
        if (pv >= 2048) s = 4095 - s;
      end
      default: s = 2048;
    endcase
    return 16'(int'(c) * 4096 + int'(s));
  endfunction

  // csb stub: answers a pending load after stub_delay cycles, holds csb low
  // for stub_hold cycles.
  initial begin
    csb = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (stub_on && load && csb) begin
        repeat (stub_delay) @(negedge sys_clk);
        csb = 1'b0;
        repeat (stub_hold) @(negedge sys_clk);
        csb = 1'b1;
      end
    end
  end

  // Monitor / reference model, sampled 1 time unit after each rising edge.
  int          mst;       // 0 idle, 1 load, 2 send
  int          nxt;
  logic [23:0] mphase;
  logic        exp_ovr;
  logic [15:0] held;
  logic        prev_en;
  logic        ivl_valid;
  int          cyc;

  initial begin
    mst = 0; mphase = '0; exp_ovr = 1'b0; held = '0;
    prev_en = 1'b0; ivl_valid = 1'b0; cyc = 0;
    forever begin
      logic        dropped;
      logic [15:0] w;
      @(posedge sys_clk);
      #1;
      if (!rst_n) begin
        mst = 0; mphase = '0; exp_ovr = 1'b0; held = '0;
        prev_en = 1'b0; ivl_valid = 1'b0; cyc = 0;
        sb_q.delete();
      end else begin
        if (enable && !prev_en) check_val("first_tick", sample_tick, 1);
        if (!enable) check_val("no_tick_disabled", sample_tick, 0);
        cyc++;
        dropped = 1'b0;
        if (sample_tick) begin
          if (ivl_valid) check_val("tick_interval", cyc, int'(rate_div) + 1);
          cyc = 0;
          ivl_valid = 1'b1;
          mphase = mphase + tuning_word;
          w = exp_word(mphase, wave_sel, cmd);
          if (mst == 0) sb_q.push_back(w);
          else dropped = 1'b1;
        end
        if (!enable) ivl_valid = 1'b0;

        nxt = mst;
        case (mst)
          0: if (sample_tick) nxt = 1;
          1: if (!csb) nxt = 2;
          default: if (csb) nxt = 0;
        endcase

        if (dropped) exp_ovr = 1'b1;
        else if (clr_overrun) exp_ovr = 1'b0;

        if (mst == 0 && nxt == 1) begin
          if (sb_q.size() == 0) begin
            check_val("sb_underflow", 1, 0);
          end else begin
            held = sb_q.pop_front();
            check_val("word", parallel_out, held);
          end
          if (lit_q.size() != 0) check_val("word_literal", parallel_out, lit_q.pop_front());
        end
        mst = nxt;

        check_val("load", load, (mst == 1));
        if (mst != 0) check_val("word_held", parallel_out, held);
        check_val("overrun", overrun, exp_ovr);
        prev_en = enable;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge sys_clk);
    enable = 1'b0;
    repeat (40) @(negedge sys_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_load(input logic lvl, input string tag);
    int n;
    n = 0;
    while (load !== lvl && n < 100) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check_val(tag, load, lvl);
  endtask

  initial begin
    logic found;
    rst_n = 1'b0; enable = 1'b0; tuning_word = '0; rate_div = '0;
    wave_sel = 2'd0; cmd = 4'd0; clr_overrun = 1'b0;
    stub_on = 1'b1; stub_delay = 5; stub_hold = 10;

    repeat (3) @(posedge sys_clk);
    #1;
    check_val("rst_parallel_out", parallel_out, 0);
    check_val("rst_load", load, 0);
    check_val("rst_sample_tick", sample_tick, 0);
    check_val("rst_overrun", overrun, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Saw: 17 words through the wrap.
    cmd = 4'h3; tuning_word = 24'h100000; rate_div = 16'd99; wave_sel = 2'd0;
    for (int i = 1; i <= 17; i++) begin
      logic [15:0] v;
      v = 16'h3000 | 16'((i % 16) * 256);
      lit_q.push_back(v);
    end
    @(negedge sys_clk);
    enable = 1'b1;
    repeat (1620) @(negedge sys_clk);
    enable = 1'b0;
    repeat (30) @(negedge sys_clk);
    check_val("saw_words_left", lit_q.size(), 0);
    check_val("saw_overrun", overrun, 0);

    // Square
    do_reset();
    cmd = 4'h0; tuning_word = 24'h400000; rate_div = 16'd29; wave_sel = 2'd1;
    stub_delay = 2; stub_hold = 5;
    lit_q.push_back(16'h0000); lit_q.push_back(16'h0FFF);
    lit_q.push_back(16'h0FFF); lit_q.push_back(16'h0000);
    lit_q.push_back(16'h0000); lit_q.push_back(16'h0FFF);
    lit_q.push_back(16'h0FFF); lit_q.push_back(16'h0000);
    enable = 1'b1;
    repeat (250) @(negedge sys_clk);
    check_val("square_words_left", lit_q.size(), 0);

    // Triangle
    do_reset();
    tuning_word = 24'h200000; wave_sel = 2'd2;
    lit_q.push_back(16'h0400); lit_q.push_back(16'h0800); lit_q.push_back(16'h0C00);
    lit_q.push_back(16'h0FFF); lit_q.push_back(16'h0BFF);
    enable = 1'b1;
    repeat (160) @(negedge sys_clk);
    check_val("tri_words_left", lit_q.size(), 0);

    // Overrun
    do_reset();
    rate_div = 16'd3; tuning_word = 24'h100000; wave_sel = 2'd0; cmd = 4'hA;
    stub_delay = 2; stub_hold = 20;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge sys_clk);
      #1;
      if (sample_tick && load) found = 1'b1;
    end
    check_val("ovr_accept_seen", found, 1);
    repeat (4) @(negedge sys_clk);
    clr_overrun = 1'b1;
    @(posedge sys_clk);
    #1;
    check_val("ovr_clr_on_tick_tick", sample_tick, 1);
    check_val("ovr_clr_on_tick", overrun, 1);
    @(negedge sys_clk);
    clr_overrun = 1'b0;
    enable = 1'b0;
    repeat (40) @(negedge sys_clk);
    check_val("ovr_sticky", overrun, 1);
    clr_overrun = 1'b1;
    @(posedge sys_clk);
    #1;
    check_val("ovr_clr_quiet", overrun, 0);
    @(negedge sys_clk);
    clr_overrun = 1'b0;

    // Reset mid-LOAD
    do_reset();
    stub_on = 1'b0; rate_div = 16'd9; cmd = 4'h5;
    lit_q.push_back(16'h5100);
    enable = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("midload_load_high", load, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midload_rst_load", load, 0);
    check_val("midload_rst_word", parallel_out, 0);
    check_val("midload_rst_overrun", overrun, 0);
    lit_q.push_back(16'h5100);
    stub_on = 1'b1; stub_delay = 1; stub_hold = 30;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;

    // Reset mid-SEND
    wait_load(1'b1, "midsend_load_rise");
    wait_load(1'b0, "midsend_load_fall");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midsend_rst_load", load, 0);
    check_val("midsend_rst_word", parallel_out, 0);
    check_val("midsend_rst_overrun", overrun, 0);
    lit_q.push_back(16'h5100);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (80) @(negedge sys_clk);
    enable = 1'b0;
    repeat (40) @(negedge sys_clk);
    check_val("reset_words_left", lit_q.size(), 0);

    // enable dropped during SEND, then resume from frozen phase
    do_reset();
    rate_div = 16'd49; cmd = 4'h6; stub_delay = 1; stub_hold = 10;
    lit_q.push_back(16'h6100);
    enable = 1'b1;
    wait_load(1'b1, "endrop_load_rise");
    wait_load(1'b0, "endrop_load_fall");
    @(negedge sys_clk);
    enable = 1'b0;
    repeat (40) @(negedge sys_clk);
    check_val("endrop_load_idle", load, 0);
    lit_q.push_back(16'h6200);
    enable = 1'b1;
    repeat (15) @(negedge sys_clk);
    enable = 1'b0;
    repeat (20) @(negedge sys_clk);
    check_val("endrop_words_left", lit_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
